// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, grant encoding, pending-slot record.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    // Slot field widths; the top-level ADDR_W/DATA_W parameters default to these.
    localparam int SLOT_ADDR_W = 32;
    localparam int SLOT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_F = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    // One pending request: fetch slots always carry we=0 and wdata=0.
    typedef struct packed {
        logic                   valid;
        logic [SLOT_ADDR_W-1:0] addr;
        logic                   we;
        logic [SLOT_DATA_W-1:0] wdata;
    } slot_t;

    // Data port wins whenever it has something pending.
    function automatic gnt_t pick_grant(input slot_t f, input slot_t d);
        pick_grant = d.valid ? GNT_D : GNT_F;
        if (!d.valid && !f.valid) begin
            pick_grant = GNT_F;
        end
    endfunction

    function automatic slot_t granted_slot(input gnt_t g, input slot_t f, input slot_t d);
        granted_slot = (g == GNT_D) ? d : f;
    endfunction

endpackage

// File: rtl/mem_req_slot.sv
// Single pending-request register: captures a request pulse, holds it until the arbiter frees it.
// Latency: captured at the pulse edge; the post-edge contents are exposed combinationally as slot_nxt.
// Backpressure: none upstream; a pulse that finds the slot occupied (and not being freed) is dropped and flagged.
module mem_req_slot
    import mem_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  slot_t cap,
    input  logic  clr,
    output slot_t slot_nxt,
    output logic  drop
);

    slot_t slot_q;

    // Next contents: free on clr, then take a new request if the slot is (or is becoming) empty.
    always_comb begin
        slot_nxt = slot_q;
        drop     = 1'b0;
        if (clr) begin
            slot_nxt.valid = 1'b0;
        end
        if (cap.valid) begin
            if (!slot_q.valid || clr) begin
                slot_nxt = cap;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Slot storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_nxt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction at a time.
// Latency: pulse at edge N -> req_valid in N+1; read done in N+3, write done in N+2 at minimum.
// Backpressure: req_ready stalls and late resp_valid stretch latency indefinitely; extra pulses on a busy slot are dropped and set overrun.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = SLOT_ADDR_W,
    parameter int DATA_W = SLOT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_done,
    input  logic              mem_read_valid,
    input  logic              mem_write_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_write_data,
    output logic [DATA_W-1:0] mem_read_data,
    output logic              data_done,
    output logic              overrun,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_we,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data
);

    state_t state;
    state_t state_nxt;
    gnt_t   gnt;

    slot_t  cap_f;
    slot_t  cap_d;
    slot_t  nxt_f;
    slot_t  nxt_d;
    slot_t  iss;
    logic   drop_f;
    logic   drop_d;

    logic   clr_f;
    logic   clr_d;
    logic   issue;
    logic   accept;
    logic   resp_hit;
    logic   fetch_done_nxt;
    logic   data_done_nxt;

    // Shape the raw port pulses into slot records; a simultaneous read+write is a write.
    always_comb begin
        cap_f       = '0;
        cap_f.valid = fetch_valid;
        cap_f.addr  = SLOT_ADDR_W'(fetch_addr);

        cap_d       = '0;
        cap_d.valid = mem_read_valid | mem_write_valid;
        cap_d.addr  = SLOT_ADDR_W'(mem_addr);
        cap_d.we    = mem_write_valid;
        cap_d.wdata = SLOT_DATA_W'(mem_write_data);
    end

    mem_req_slot u_slot_f (
        .clk      (clk),
        .rst      (rst),
        .cap      (cap_f),
        .clr      (clr_f),
        .slot_nxt (nxt_f),
        .drop     (drop_f)
    );

    mem_req_slot u_slot_d (
        .clk      (clk),
        .rst      (rst),
        .cap      (cap_d),
        .clr      (clr_d),
        .slot_nxt (nxt_d),
        .drop     (drop_d)
    );

    // Issue looks at post-edge slot contents so a pulse at edge N can raise req_valid in N+1.
    assign issue    = (state == IDLE) && (nxt_f.valid || nxt_d.valid);
    assign iss      = granted_slot(pick_grant(nxt_f, nxt_d), nxt_f, nxt_d);
    assign accept   = (state == REQ) && req_valid && req_ready;
    assign resp_hit = (state == RESP) && resp_valid;

    // State and grant registers; the grant is frozen when a request is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= GNT_F;
        end else begin
            state <= state_nxt;
            if (issue) begin
                gnt <= pick_grant(nxt_f, nxt_d);
            end
        end
    end

    // Next-state: writes finish on acceptance, reads wait for the response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (nxt_f.valid || nxt_d.valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (accept) begin
                    state_nxt = req_we ? IDLE : RESP;
                end
            end
            RESP: begin
                if (resp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completion decode: which slot to free and which done pulse to raise.
    always_comb begin
        clr_f          = 1'b0;
        clr_d          = 1'b0;
        fetch_done_nxt = 1'b0;
        data_done_nxt  = 1'b0;
        if (accept && req_we) begin
            clr_d         = 1'b1;
            data_done_nxt = 1'b1;
        end
        if (resp_hit) begin
            if (gnt == GNT_D) begin
                clr_d         = 1'b1;
                data_done_nxt = 1'b1;
            end else begin
                clr_f          = 1'b1;
                fetch_done_nxt = 1'b1;
            end
        end
    end

    // Registered outputs: request channel, done pulses, held read data, sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid     <= 1'b0;
            req_addr      <= '0;
            req_we        <= 1'b0;
            req_wdata     <= '0;
            fetch_done    <= 1'b0;
            data_done     <= 1'b0;
            fetch_data    <= '0;
            mem_read_data <= '0;
            overrun       <= 1'b0;
        end else begin
            fetch_done <= fetch_done_nxt;
            data_done  <= data_done_nxt;
            overrun    <= overrun | drop_f | drop_d;
            if (issue) begin
                req_valid <= 1'b1;
                req_addr  <= ADDR_W'(iss.addr);
                req_we    <= iss.we;
                req_wdata <= DATA_W'(iss.wdata);
            end else if (accept) begin
                req_valid <= 1'b0;
            end
            if (resp_hit) begin
                if (gnt == GNT_D) begin
                    mem_read_data <= resp_data;
                end else begin
                    fetch_data <= resp_data;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory between the core's instruction-fetch port and its load/store data port. Latches the core's single-cycle request pulses into per-port pending slots, issues them to memory one at a time over a valid/ready request channel, and returns read data with a one-cycle done pulse per port. Sits between the core and the unified instruction/data memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `fetch_valid`  in  1  one-cycle fetch request pulse
- `fetch_addr`  in  ADDR_W  fetch address, sampled with `fetch_valid`
- `fetch_data`  out  DATA_W  fetched word; held until the next fetch completes
- `fetch_done`  out  1  one-cycle pulse; `fetch_data` is valid
- `mem_read_valid`  in  1  one-cycle load request pulse
- `mem_write_valid`  in  1  one-cycle store request pulse
- `mem_addr`  in  ADDR_W  load/store address
- `mem_write_data`  in  DATA_W  store data
- `mem_read_data`  out  DATA_W  load result; held until the next load completes
- `data_done`  out  1  one-cycle pulse; load data valid or store accepted
- `overrun`  out  1  sticky; a request arrived while that port's slot was occupied
- `req_valid`  out  1  memory request valid
- `req_ready`  in  1  memory accepts request
- `req_addr`  out  ADDR_W  request address
- `req_we`  out  1  1 = write
- `req_wdata`  out  DATA_W  write data
- `resp_valid`  in  1  read response valid
- `resp_data`  in  DATA_W  read response data

## Operation
- Two pending slots, F (fetch) and D (data), each holding valid, addr, we, wdata.
- Capture: a pulse on a port with an empty slot fills it at the edge. A pulse on an occupied slot is dropped and sets `overrun`. A slot being freed at this edge counts as empty, so back-to-back requests are accepted.
- `mem_read_valid` and `mem_write_valid` both high: treated as a write.
- FSM states: IDLE, REQ, RESP.
  - IDLE → REQ when any slot is valid. Grant goes to D if D is valid, else F. The grant is fixed at REQ entry.
  - REQ: drive `req_*` from the granted slot.
    - On `req_valid && req_ready` for a read: go to RESP.
    - On `req_valid && req_ready` for a write: clear slot D, pulse `data_done` next cycle, go to IDLE.
  - RESP: wait for `resp_valid`. On `resp_valid`:
    - Register `resp_data` into `fetch_data` or `mem_read_data` according to the grant.
    - Pulse the matching done signal.
    - Clear the slot and go to IDLE.
- `resp_valid` in IDLE or REQ is ignored.
- `req_*` outputs are stable while `req_valid` is high and not yet accepted.
- Only one transaction is outstanding at any time.

## Timing
- All outputs are registered.
- Reset values:
  - `fetch_data` and `mem_read_data`: 0.
  - `fetch_done`, `data_done`, `overrun`, `req_valid`, `req_we`: 0.
  - `req_addr`, `req_wdata`: 0.
  - State IDLE, both slots empty.
- Pulse captured at edge N → `req_valid` high in cycle N+1.
- Minimum read latency: `req_ready` in N+1 and `resp_valid` in N+2 → done pulse and data visible in N+3.
- Minimum write latency: `req_ready` in N+1 → `data_done` in N+2.
- `req_ready` stalls and `resp_valid` delays extend the latency cycle-for-cycle, with no timeout.
- Both ports pulse in the same cycle: both are captured. D is served first, and F is issued on the cycle after D completes (IDLE→REQ takes one cycle).
- Reset mid-transaction: state, slots and pulses clear immediately. `overrun` clears. A late `resp_valid` after reset is discarded.
- `overrun` clears only on reset.

## Structure
- Package `mem_arbiter_pkg` contains:
  - State enum (IDLE/REQ/RESP).
  - Grant encoding (GNT_F/GNT_D).
  - Slot struct: valid, addr, we, wdata.
- Sub-module `mem_req_slot` implements the capture/hold/clear register with overrun detection. It is instantiated twice.
- The FSM, grant logic and response steering live in the top module.

## Test plan
- Fetch of addr 0x0000_0010, with `req_ready` in N+1 and `resp_data` 0xDEAD_BEEF in N+2 → `req_addr` = 0x10 and `req_we` = 0; `fetch_done` and `fetch_data` = 0xDEADBEEF in N+3.
- Simultaneous fetch 0x20 and store to 0x100 with data 0x1234_5678 → the first request is a write to 0x100 with `req_wdata` 0x12345678 and `data_done`. The fetch to 0x20 is issued afterwards, and `fetch_done` returns its data.
- `req_ready` held low for 5 cycles during a load of 0x44 → `req_addr`/`req_we` stable throughout. `mem_read_data` is updated only after `resp_valid`, and `fetch_data` is unchanged.
- Second fetch pulse while the first fetch is pending → `overrun` goes to 1 and stays there. Only one fetch reaches memory.
- `rst` asserted while in RESP, then `resp_valid` pulsed after deassertion → all outputs 0 during and after reset, and no done pulse.
- Fetch issued in the same cycle as the previous `fetch_done` → accepted, no overrun, and the second fetch completes normally.
